// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor scan scheduler.
// State encoding, slot-to-channel map and SPI command word builder.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DEAD,
    READ
  } state_t;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  function automatic logic [2:0] slot_ch(
    input logic [1:0] s
  );
    logic [2:0] c;
    unique case (s)
      2'd0: c = CH_LFT;
      2'd1: c = CH_RGHT;
      2'd2: c = CH_STEER;
      default: c = CH_BATT;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] cmd_word(
    input logic [2:0] ch
  );
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/sensor_scan_sched.sv
// Round-robin A2D scan scheduler driving a shared SPI monarch.
// Ports: clk/rst_n, nxt/en_mask request, wrt/wt_data/done/rd_data SPI,
// four 12-bit results, busy, cnv_done/cnv_slot completion strobe.
module sensor_scan_sched
  import sensor_pkg::*;
#(
  parameter int DEAD_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic [3:0]  en_mask,
  output logic        wrt,
  output logic [15:0] wt_data,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        cnv_done,
  output logic [1:0]  cnv_slot
);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wrt_q, wrt_d;
  logic [15:0]       wt_data_q, wt_data_d;
  logic              cnv_done_q, cnv_done_d;
  logic [1:0]        cnv_slot_q, cnv_slot_d;
  logic [3:0][11:0]  res_q, res_d;

  logic [1:0] pick;
  logic [1:0] cand;
  logic       start;

  // Upper receive bits carry no result data.
  logic unused_rd;
  assign unused_rd = &{1'b0, rd_data[15:12]};

  assign start = nxt && (en_mask != 4'h0);

  // Walk down from the farthest offset so the nearest enabled
  // slot at or after ptr is the last (winning) assignment.
  always_comb begin
    pick = ptr_q;
    cand = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (en_mask[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      cnt_q      <= 4'd0;
      wrt_q      <= 1'b0;
      wt_data_q  <= 16'h0000;
      cnv_done_q <= 1'b0;
      cnv_slot_q <= 2'd0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      wrt_q      <= wrt_d;
      wt_data_q  <= wt_data_d;
      cnv_done_q <= cnv_done_d;
      cnv_slot_q <= cnv_slot_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CMD;
      CMD:  if (done) state_d = DEAD;
      DEAD: if (cnt_q == 4'd0) state_d = READ;
      READ: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    wrt_d      = 1'b0;
    wt_data_d  = wt_data_q;
    cnv_done_d = 1'b0;
    cnv_slot_d = cnv_slot_q;
    res_d      = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          wrt_d     = 1'b1;
          wt_data_d = cmd_word(slot_ch(pick));
          sel_d     = pick;
        end
      end
      CMD: begin
        if (done) cnt_d = 4'(DEAD_CYC - 1);
      end
      DEAD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wrt_d     = 1'b1;
          wt_data_d = 16'h0000;
        end
      end
      READ: begin
        if (done) begin
          res_d[sel_q] = rd_data[11:0];
          cnv_done_d   = 1'b1;
          cnv_slot_d   = sel_q;
          ptr_d        = sel_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign wrt       = wrt_q;
  assign wt_data   = wt_data_q;
  assign cnv_done  = cnv_done_q;
  assign cnv_slot  = cnv_slot_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule

// File: tb/tb_sensor_scan_sched.sv
// Directed bench for sensor_scan_sched with a simple SPI peer model.
// A second instance with DEAD_CYC=3 is driven by hand for dead-time checks.
module tb_sensor_scan_sched;

  logic        clk;
  logic        rst_n;
  logic        nxt;
  logic [3:0]  en_mask;
  logic        wrt;
  logic [15:0] wt_data;
  logic        done_w;
  logic [15:0] rd_data;
  logic [11:0] lft, rght, steer, batt;
  logic        busy, cnv_done;
  logic [1:0]  cnv_slot;

  logic        nxt3;
  logic [3:0]  en3;
  logic        wrt3;
  logic [15:0] wt_data3;
  logic        done3;
  logic [15:0] rd3;
  logic [11:0] lft3, rght3, steer3, batt3;
  logic        busy3, cnv_done3;
  logic [1:0]  cnv_slot3;

  logic        spi_done;
  logic        inj_done;
  logic [11:0] rd_tab [8];
  logic [15:0] cmd_log [$];
  bit          phase;
  int          cur_ch;

  int wrt_cnt, cnv_cnt, b2b;
  logic wrt_prev;
  int pass_cnt, total_cnt;

  assign done_w = spi_done | inj_done;

  sensor_scan_sched u_dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .en_mask(en_mask),
    .wrt(wrt), .wt_data(wt_data), .done(done_w), .rd_data(rd_data),
    .lft_ld(lft), .rght_ld(rght), .steer_pot(steer), .batt(batt),
    .busy(busy), .cnv_done(cnv_done), .cnv_slot(cnv_slot)
  );

  sensor_scan_sched #(.DEAD_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .nxt(nxt3), .en_mask(en3),
    .wrt(wrt3), .wt_data(wt_data3), .done(done3), .rd_data(rd3),
    .lft_ld(lft3), .rght_ld(rght3), .steer_pot(steer3), .batt(batt3),
    .busy(busy3), .cnv_done(cnv_done3), .cnv_slot(cnv_slot3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI peer: done three negedges after seeing wrt; first wrt of a
  // conversion is the command, second is the read.
  initial begin
    spi_done = 1'b0;
    rd_data  = 16'h0000;
    phase    = 1'b0;
    cur_ch   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 1'b0;
      end else if (wrt) begin
        if (!phase) begin
          cmd_log.push_back(wt_data);
          cur_ch = int'(wt_data[13:11]);
        end
        repeat (3) @(negedge clk);
        spi_done = 1'b1;
        rd_data  = phase ? {4'hF, rd_tab[cur_ch]} : 16'h5A5A;
        @(negedge clk);
        spi_done = 1'b0;
        phase    = ~phase;
      end
    end
  end

  initial begin
    wrt_cnt  = 0;
    cnv_cnt  = 0;
    b2b      = 0;
    wrt_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wrt) begin
        wrt_cnt++;
        if (wrt_prev) b2b++;
      end
      wrt_prev = wrt;
      if (cnv_done) cnv_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    nxt   = 1'b0;
    nxt3  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_conv(output int lat, output logic [1:0] slot);
    lat  = 0;
    slot = 2'bxx;
    nxt  = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) nxt = 1'b0;
      if (cnv_done) begin
        lat  = k;
        slot = cnv_slot;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({wrt, busy, cnv_done, cnv_slot, wt_data, lft, rght, steer, batt} !== 69'd0)
      $display("FAIL reset_outs got %h want 0",
        {wrt, busy, cnv_done, cnv_slot, wt_data, lft, rght, steer, batt});
    else pass_cnt++;
    total_cnt++;
    if ({wrt3, busy3, cnv_done3, lft3, rght3, steer3, batt3} !== 51'd0)
      $display("FAIL reset_outs3 got %h want 0",
        {wrt3, busy3, cnv_done3, lft3, rght3, steer3, batt3});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan4();
    int lat;
    logic [1:0] slot;
    logic [15:0] exp_cmd [4];
    exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
    en_mask = 4'hF;
    cmd_log.delete();
    for (int i = 0; i < 4; i++) begin
      do_conv(lat, slot);
      total_cnt++;
      if (lat !== 10) $display("FAIL scan4_lat[%0d] got %0d want 10", i, lat);
      else pass_cnt++;
      total_cnt++;
      if (slot !== 2'(i)) $display("FAIL scan4_slot[%0d] got %0d want %0d", i, slot, i);
      else pass_cnt++;
    end
    total_cnt++;
    if ({lft, rght, steer, batt} !== 48'hA11_B22_C33_D44)
      $display("FAIL scan4_res got %h want a11b22c33d44", {lft, rght, steer, batt});
    else pass_cnt++;
    total_cnt++;
    if (cmd_log.size() !== 4) $display("FAIL scan4_ncmd got %0d want 4", cmd_log.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
      total_cnt++;
      if (cmd_log[i] !== exp_cmd[i])
        $display("FAIL scan4_cmd[%0d] got %h want %h", i, cmd_log[i], exp_cmd[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mask_1010();
    int lat;
    logic [1:0] slot;
    logic [1:0] exp_s [3];
    exp_s = '{2'd1, 2'd3, 2'd1};
    apply_reset();
    en_mask = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      do_conv(lat, slot);
      total_cnt++;
      if (slot !== exp_s[i])
        $display("FAIL m1010_slot[%0d] got %0d want %0d", i, slot, exp_s[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({lft, rght, steer, batt} !== 48'h000_B22_000_D44)
      $display("FAIL m1010_res got %h want 000b22000d44", {lft, rght, steer, batt});
    else pass_cnt++;
  endtask

  task automatic test_nxt_hold();
    int w0, c0, b0;
    en_mask = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    w0 = wrt_cnt;
    c0 = cnv_cnt;
    b0 = b2b;
    nxt = 1'b1;
    repeat (50) @(negedge clk);
    nxt = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total_cnt++;
    if (cnv_cnt - c0 !== 5) $display("FAIL hold_cnv got %0d want 5", cnv_cnt - c0);
    else pass_cnt++;
    total_cnt++;
    if (wrt_cnt - w0 !== 10) $display("FAIL hold_wrt got %0d want 10", wrt_cnt - w0);
    else pass_cnt++;
    total_cnt++;
    if (b2b - b0 !== 0) $display("FAIL hold_b2b got %0d want 0", b2b - b0);
    else pass_cnt++;
  endtask

  task automatic test_mask_zero();
    int w0, c0, lat;
    logic busy_seen;
    logic [1:0] slot;
    apply_reset();
    en_mask = 4'h0;
    #1;
    w0 = wrt_cnt;
    c0 = cnv_cnt;
    busy_seen = 1'b0;
    nxt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) nxt = 1'b0;
      if (k == 3) inj_done = 1'b1;
      if (k == 4) inj_done = 1'b0;
      busy_seen = busy_seen | busy;
    end
    #1;
    total_cnt++;
    if (wrt_cnt - w0 !== 0) $display("FAIL m0_wrt got %0d want 0", wrt_cnt - w0);
    else pass_cnt++;
    total_cnt++;
    if (busy_seen !== 1'b0) $display("FAIL m0_busy got %b want 0", busy_seen);
    else pass_cnt++;
    total_cnt++;
    if (cnv_cnt - c0 !== 0) $display("FAIL m0_cnv got %0d want 0", cnv_cnt - c0);
    else pass_cnt++;
    en_mask = 4'h4;
    do_conv(lat, slot);
    total_cnt++;
    if (slot !== 2'd2) $display("FAIL m4_slot got %0d want 2", slot);
    else pass_cnt++;
    total_cnt++;
    if ({lft, rght, steer, batt} !== 48'h000_000_C33_000)
      $display("FAIL m4_res got %h want 000000c33000", {lft, rght, steer, batt});
    else pass_cnt++;
  endtask

  task automatic test_reset_dead();
    int lat;
    logic [1:0] slot;
    apply_reset();
    en_mask = 4'h1;
    rd_tab[0] = 12'h123;
    do_conv(lat, slot);
    total_cnt++;
    if (lft !== 12'h123) $display("FAIL rd_pre got %h want 123", lft);
    else pass_cnt++;
    en_mask = 4'hF;
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rd_busy got %b want 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({wrt, busy, cnv_done, cnv_slot, wt_data, lft, rght, steer, batt} !== 69'd0)
      $display("FAIL rd_zero got %h want 0",
        {wrt, busy, cnv_done, cnv_slot, wt_data, lft, rght, steer, batt});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_tab[0] = 12'hA11;
    @(negedge clk);
    do_conv(lat, slot);
    total_cnt++;
    if (slot !== 2'd0) $display("FAIL rd_post_slot got %0d want 0", slot);
    else pass_cnt++;
    total_cnt++;
    if (lft !== 12'hA11) $display("FAIL rd_post_res got %h want a11", lft);
    else pass_cnt++;
  endtask

  task automatic test_dead3();
    int gap;
    apply_reset();
    en3 = 4'b0010;
    nxt3 = 1'b1;
    @(negedge clk);
    nxt3 = 1'b0;
    total_cnt++;
    if ({wrt3, busy3, wt_data3} !== {2'b11, 16'h2000})
      $display("FAIL d3_cmd got %b%b %h want 11 2000", wrt3, busy3, wt_data3);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wrt3 !== 1'b0) $display("FAIL d3_wrt_low got %b want 0", wrt3);
    else pass_cnt++;
    done3 = 1'b1;
    @(negedge clk);
    done3 = 1'b0;
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) done3 = 1'b1;
      if (k == 2) done3 = 1'b0;
      if (wrt3) begin
        gap = k;
        break;
      end
    end
    total_cnt++;
    if (gap !== 3) $display("FAIL d3_gap got %0d want 3", gap);
    else pass_cnt++;
    total_cnt++;
    if (wt_data3 !== 16'h0000) $display("FAIL d3_rdcmd got %h want 0000", wt_data3);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (wrt3 !== 1'b0) $display("FAIL d3_no_b2b got %b want 0", wrt3);
    else pass_cnt++;
    rd3 = 16'hF789;
    done3 = 1'b1;
    @(negedge clk);
    done3 = 1'b0;
    total_cnt++;
    if ({cnv_done3, cnv_slot3, busy3} !== 4'b1010)
      $display("FAIL d3_done got %b%0d%b want 1 1 0", cnv_done3, cnv_slot3, busy3);
    else pass_cnt++;
    total_cnt++;
    if ({lft3, rght3, steer3, batt3} !== 48'h000_789_000_000)
      $display("FAIL d3_res got %h want 000789000000", {lft3, rght3, steer3, batt3});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < 8; i++) rd_tab[i] = 12'h000;
    rd_tab[0] = 12'hA11;
    rd_tab[4] = 12'hB22;
    rd_tab[5] = 12'hC33;
    rd_tab[6] = 12'hD44;
    nxt      = 1'b0;
    en_mask  = 4'h0;
    inj_done = 1'b0;
    nxt3     = 1'b0;
    en3      = 4'h0;
    done3    = 1'b0;
    rd3      = 16'h0000;
    test_reset();
    test_scan4();
    test_mask_1010();
    test_nxt_hold();
    test_mask_zero();
    test_reset_dead();
    test_dead3();
    total_cnt++;
    if (b2b !== 0) $display("FAIL wrt_b2b got %0d want 0", b2b);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sensor_scan_sched.md
SENSOR_SCAN_SCHED -- requirements
Module: sensor_scan_sched

Interface
REQ-001 The block SHALL have the parameter DEAD_CYC, default 1, giving the idle clocks between the command and read SPI transactions (legal range 1..15).
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- nxt  in  1  one-clock request to convert the next enabled channel.
- en_mask  in  4  per-slot enable: bit0 lft_ld, bit1 rght_ld, bit2 steer_pot, bit3 batt.
- wrt  out  1  one-clock start pulse to the shared SPI monarch.
- wt_data  out  16  SPI command word.
- done  in  1  one-clock SPI transaction-complete pulse.
- rd_data  in  16  SPI receive word, valid while done=1.
- lft_ld  out  12  last left load-cell result.
- rght_ld  out  12  last right load-cell result.
- steer_pot  out  12  last steering-pot result.
- batt  out  12  last battery result.
- busy  out  1  high while a conversion is in progress.
- cnv_done  out  1  one-clock pulse when a result register updates.
- cnv_slot  out  2  index of the slot just updated; valid with cnv_done.

Function
REQ-003 Slot-to-A2D channel mapping SHALL be: slot0->ch0, slot1->ch4, slot2->ch5, slot3->ch6.
REQ-004 wt_data SHALL be {2'b00, chnl[2:0], 11'h000} for the command transaction, and 16'h0000 for the read transaction.
REQ-005 The FSM states SHALL be IDLE, CMD, DEAD and READ.
REQ-006 IDLE -> CMD: on the clock where nxt=1 and en_mask!=0. wrt SHALL pulse on that same edge with the command word, and the selected slot SHALL be latched.
REQ-007 Slot selection SHALL be the first enabled slot at or after ptr, searching upward modulo 4. ptr resets to 0.
REQ-008 CMD -> DEAD on done. The block SHALL then wait DEAD_CYC clocks.
REQ-009 DEAD -> READ when the dead count expires, with wrt pulsed once carrying 16'h0000.
REQ-010 READ -> IDLE on done, with the following actions on that edge:
- latch rd_data[11:0] into the selected slot's register;
- pulse cnv_done for one clock;
- drive cnv_slot with the selected slot;
- set ptr to selected slot + 1 (mod 4).
REQ-011 Latency from nxt to cnv_done SHALL be 2 SPI transactions + DEAD_CYC + 1 clocks.
REQ-012 busy SHALL be 1 in CMD, DEAD and READ, and 0 in IDLE.
REQ-013 nxt asserted while busy=1 SHALL be ignored; it is not queued.
REQ-014 nxt with en_mask==0 SHALL be ignored: no wrt and no state change.
REQ-015 en_mask changes during a conversion SHALL NOT abort it. The new mask applies from the next selection onward.
REQ-016 A done arriving in IDLE or DEAD SHALL be ignored.
REQ-017 wrt SHALL never be high on two consecutive clocks.
REQ-018 Result registers not being converted SHALL hold their values.

Reset
REQ-019 rst_n low SHALL asynchronously force the following, regardless of operation in progress:
- state IDLE, ptr 0;
- wrt, busy, cnv_done 0;
- cnv_slot 0, wt_data 0;
- all four result registers 12'h000.
REQ-020 After reset is released, the first nxt SHALL start from slot0 (subject to en_mask).

Structure
REQ-021 The state enum and the slot-to-channel constants SHALL live in a shared package, sensor_pkg.
REQ-022 The block SHALL be a single module with no sub-modules. The SPI monarch SHALL be a separate peer, connected only via wrt, wt_data, done and rd_data.

Verification
REQ-023 After reset, with en_mask=4'hF, four nxt pulses and an SPI model returning 12'hA11/B22/C33/D44:
- lft_ld=A11, rght_ld=B22, steer_pot=C33, batt=D44;
- wt_data command channels observed in order 0, 4, 5, 6.
REQ-024 en_mask=4'b1010 with three nxt pulses -> slots converted 1, 3, 1; lft_ld and steer_pot remain 12'h000.
REQ-025 With nxt held high for 50 clocks during a conversion -> exactly one cnv_done, and exactly two wrt pulses, per conversion.
REQ-026 With en_mask=0 and nxt pulsed -> no wrt and busy stays 0. Then with en_mask=4'h4 and nxt pulsed -> steer_pot is updated.
REQ-027 rst_n asserted in DEAD after lft_ld=12'h123 -> all outputs 0 immediately. The next nxt converts slot0.
REQ-028 With DEAD_CYC=3 -> exactly 3 clocks between the first done and the second wrt. A spurious done injected in DEAD is ignored.
